// File: rtl/falafel_req_frontend.sv
// falafel_req_frontend: message front end of the falafel allocator.
// Parses 2-word host requests (header + payload), owns the configuration
// register file (per-class free-list pointers, lock pointer, lock id) and
// dispatches aligned alloc / free commands to the allocator core.
// Register reads, alloc overflow and optional write acks return on rsp_*.
// Optional feature macro: FALAFEL_REG_WRITE_ACK_EN (register writes answer on rsp_*).
module falafel_req_frontend #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned ALIGN       = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic                          cmd_valid_o,
    input  logic                          cmd_ready_i,
    output logic                          cmd_free_o,
    output logic [7:0]                    cmd_id_o,
    output logic [DATA_W-1:0]             cmd_data_o,
    output logic [2:0]                    cmd_class_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [7:0]                    rsp_id_o,
    output logic [DATA_W-1:0]             rsp_data_o,
    output logic [NUM_CLASSES*DATA_W-1:0] free_list_ptr_o,
    output logic [DATA_W-1:0]             lock_ptr_o,
    output logic [DATA_W-1:0]             lock_id_o,
    output logic [15:0]                   err_cnt_o
);

    localparam int unsigned       ALIGN_LG = $clog2(ALIGN);
    localparam logic [DATA_W-1:0] ALIGN_M1 = DATA_W'(ALIGN - 1);
    // Largest size that still aligns without wrapping: 2^DATA_W - ALIGN.
    localparam logic [DATA_W-1:0] MAX_SIZE = ~ALIGN_M1;

    localparam logic [3:0] OP_REG   = 4'd0;
    localparam logic [3:0] OP_ALLOC = 4'd1;
    localparam logic [3:0] OP_FREE  = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CMD     = 2'd2,
        ST_RSP     = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched header fields
    logic [3:0]  hdr_op_q;
    logic [7:0]  hdr_id_q;
    logic [15:0] hdr_addr_q;
    logic        hdr_wr_q;

    // Register file
    logic [NUM_CLASSES-1:0][DATA_W-1:0] free_q;
    logic [DATA_W-1:0]                  lock_ptr_q;
    logic [DATA_W-1:0]                  lock_id_q;
    logic [15:0]                        err_cnt_q;

    // Command / response holding registers
    logic              cmd_free_q, cmd_free_d;
    logic [7:0]        cmd_id_q;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic [2:0]        cmd_class_q, cmd_class_d;
    logic [7:0]        rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Decode / datapath signals
    logic [NUM_CLASSES-1:0] sel_fl;
    logic                   sel_lptr, sel_lid, addr_hit;
    logic [DATA_W-1:0]      rd_data;
    logic [DATA_W-1:0]      size_pad, aligned, blocks;
    logic [2:0]             alloc_class;
    logic                   class_found;
    logic                   alloc_ovf;
    logic                   cmd_load, rsp_load, reg_wr, err_inc;

    // Register address decode and read mux for the latched address
    always_comb begin
        sel_fl    = '0;
        sel_fl[0] = (hdr_addr_q == 16'h0010);
        for (int unsigned k = 1; k < NUM_CLASSES; k++) begin
            sel_fl[k] = (hdr_addr_q == 16'(32'h40 + 8 * (k - 1)));
        end
        sel_lptr = (hdr_addr_q == 16'h0018);
        sel_lid  = (hdr_addr_q == 16'h0020);
        addr_hit = (|sel_fl) | sel_lptr | sel_lid;
        rd_data  = '0;
        if (sel_lptr) rd_data = lock_ptr_q;
        if (sel_lid)  rd_data = lock_id_q;
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            if (sel_fl[k]) rd_data = free_q[k];
        end
    end

    // Alloc size alignment, size-class selection and overflow detection
    always_comb begin
        size_pad    = (in_data_i < DATA_W'(ALIGN)) ? DATA_W'(ALIGN) : in_data_i;
        aligned     = (size_pad + ALIGN_M1) & ~ALIGN_M1;
        blocks      = aligned >> ALIGN_LG;
        alloc_class = 3'(NUM_CLASSES - 1);
        class_found = 1'b0;
        // Smallest c with 2^c >= blocks, i.e. ceil_log2, saturating at the last class.
        for (int unsigned c = 0; c + 1 < NUM_CLASSES; c++) begin
            if (!class_found && (blocks <= (DATA_W'(1) << c))) begin
                alloc_class = 3'(c);
                class_found = 1'b1;
            end
        end
        alloc_ovf = (in_data_i > MAX_SIZE);
    end

    // FSM next-state and per-message actions
    always_comb begin
        state_d     = state_q;
        cmd_load    = 1'b0;
        rsp_load    = 1'b0;
        reg_wr      = 1'b0;
        err_inc     = 1'b0;
        cmd_free_d  = 1'b0;
        cmd_data_d  = '0;
        cmd_class_d = '0;
        rsp_data_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (in_valid_i) begin
                    state_d = ST_IDLE;
                    case (hdr_op_q)
                        OP_REG: begin
                            if (hdr_wr_q) begin
                                reg_wr  = addr_hit;
                                err_inc = !addr_hit;
`ifdef FALAFEL_REG_WRITE_ACK_EN
                                rsp_load   = 1'b1;
                                rsp_data_d = addr_hit ? in_data_i : '0;
                                state_d    = ST_RSP;
`endif
                            end else begin
                                rsp_load   = 1'b1;
                                rsp_data_d = rd_data;
                                err_inc    = !addr_hit;
                                state_d    = ST_RSP;
                            end
                        end
                        OP_ALLOC: begin
                            if (alloc_ovf) begin
                                rsp_load = 1'b1;
                                err_inc  = 1'b1;
                                state_d  = ST_RSP;
                            end else begin
                                cmd_load    = 1'b1;
                                cmd_data_d  = aligned;
                                cmd_class_d = alloc_class;
                                state_d     = ST_CMD;
                            end
                        end
                        OP_FREE: begin
                            if (in_data_i == '0) begin
                                err_inc = 1'b1;
                            end else begin
                                cmd_load   = 1'b1;
                                cmd_free_d = 1'b1;
                                cmd_data_d = in_data_i;
                                state_d    = ST_CMD;
                            end
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            ST_CMD: begin
                if (cmd_ready_i) state_d = ST_IDLE;
            end
            ST_RSP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Header latch, register file, holding registers and error counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_op_q    <= '0;
            hdr_id_q    <= '0;
            hdr_addr_q  <= '0;
            hdr_wr_q    <= 1'b0;
            free_q      <= '0;
            lock_ptr_q  <= '0;
            lock_id_q   <= '0;
            err_cnt_q   <= '0;
            cmd_free_q  <= 1'b0;
            cmd_id_q    <= '0;
            cmd_data_q  <= '0;
            cmd_class_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && in_valid_i) begin
                hdr_op_q   <= in_data_i[3:0];
                hdr_id_q   <= in_data_i[11:4];
                hdr_addr_q <= in_data_i[27:12];
                hdr_wr_q   <= in_data_i[28];
            end
            if (reg_wr) begin
                if (sel_lptr) lock_ptr_q <= in_data_i;
                if (sel_lid)  lock_id_q  <= in_data_i;
                for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                    if (sel_fl[k]) free_q[k] <= in_data_i;
                end
            end
            if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (cmd_load) begin
                cmd_free_q  <= cmd_free_d;
                cmd_id_q    <= hdr_id_q;
                cmd_data_q  <= cmd_data_d;
                cmd_class_q <= cmd_class_d;
            end
            if (rsp_load) begin
                rsp_id_q   <= hdr_id_q;
                rsp_data_q <= rsp_data_d;
            end
        end
    end

    assign in_ready_o      = (state_q == ST_IDLE) || (state_q == ST_PAYLOAD);
    assign cmd_valid_o     = (state_q == ST_CMD);
    assign rsp_valid_o     = (state_q == ST_RSP);
    assign cmd_free_o      = cmd_free_q;
    assign cmd_id_o        = cmd_id_q;
    assign cmd_data_o      = cmd_data_q;
    assign cmd_class_o     = cmd_class_q;
    assign rsp_id_o        = rsp_id_q;
    assign rsp_data_o      = rsp_data_q;
    assign free_list_ptr_o = free_q;
    assign lock_ptr_o      = lock_ptr_q;
    assign lock_id_o       = lock_id_q;
    assign err_cnt_o       = err_cnt_q;

endmodule

// File: doc/falafel_req_frontend.md
Name: falafel_req_frontend

Overview:
- Message front end of the falafel allocator. Sits between the host request stream and the allocator core.
- Parses 2-word requests and owns the configuration register file. Unlike the earlier single-free-list scheme, it has NUM_CLASSES size-class free-list pointers.
- Aligns alloc sizes, picks the size class, and dispatches alloc/free commands to the core. Register reads return on a response channel.

Parameters:
- DATA_W, 64, word width
- NUM_CLASSES, 4, number of size-class free lists (1..8)
- ALIGN, 64, block alignment in bytes; power of two, also the minimum payload size

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  request word valid
- in_ready_o  out  1  request word accepted when valid&ready
- in_data_i  in  DATA_W  request word
- cmd_valid_o  out  1  core command valid
- cmd_ready_i  in  1  core accepts command
- cmd_free_o  out  1  0=alloc, 1=free
- cmd_id_o  out  8  message id
- cmd_data_o  out  DATA_W  aligned size (alloc) or pointer (free)
- cmd_class_o  out  3  size class index (alloc only; 0 for free)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_id_o  out  8  message id
- rsp_data_o  out  DATA_W  read data or ERR_NOMEM (0)
- free_list_ptr_o  out  NUM_CLASSES*DATA_W  class k at bits [k*DATA_W +: DATA_W]
- lock_ptr_o  out  DATA_W  lock pointer register
- lock_id_o  out  DATA_W  lock id register
- err_cnt_o  out  16  saturating protocol-error count

Behaviour:
- Header word fields: [3:0] opcode, [11:4] id, [27:12] reg addr, [28] write flag (register access only).
- Opcodes: 0 register access, 1 alloc, 2 free.
- Payload word: write data / alloc size / free pointer.
- Reset: state IDLE; every register, counter and valid output is 0.
- in_ready_o = 1 only in IDLE and PAYLOAD (decoded from state).
- FSM:
  - IDLE: on a header handshake, latch the header and go to PAYLOAD.
  - PAYLOAD: on a payload handshake, compute and go to CMD, RSP or IDLE.
  - CMD: hold cmd_* stable while cmd_valid_o=1; on cmd_ready_i go to IDLE.
  - RSP: hold rsp_* stable while rsp_valid_o=1; on rsp_ready_i go to IDLE.
- Latency: payload handshake at cycle N; cmd_valid_o or rsp_valid_o registered high at N+1. Register write takes effect at N+1.
- Address map:
  - 0x10: free list 0
  - 0x18: lock_ptr
  - 0x20: lock_id
  - 0x40+8*(k-1): free list k, for k = 1..NUM_CLASSES-1
- Register read: go to RSP with rsp_data_o = register value. Unmapped address returns 0 and increments err_cnt_o.
- Register write to a mapped address: update the register, go to IDLE, no response. Unmapped address: no update, increment err_cnt_o.
- Alloc:
  - s = max(size, ALIGN); aligned = (s + ALIGN-1) & ~(ALIGN-1).
  - class = min(NUM_CLASSES-1, ceil_log2(aligned/ALIGN)).
  - Go to CMD.
- Alloc overflow: if size > 2^DATA_W - ALIGN, do not issue a cmd. Go to RSP with rsp_data_o = 0 (ERR_NOMEM) and increment err_cnt_o.
- Free: cmd_free_o=1, cmd_data_o = pointer, class 0. A NULL pointer (0) is dropped, increments err_cnt_o, returns to IDLE.
- Unknown opcode (3..15): payload is still consumed, then the message is dropped and err_cnt_o increments.
- err_cnt_o saturates at 0xFFFF.
- Backpressure: no new header is accepted until the outstanding cmd/rsp handshakes. cmd and rsp are never valid together.
- Reset mid-message: the partial header is discarded, valids drop asynchronously, registers clear to 0.

Optional Feature:
- FALAFEL_REG_WRITE_ACK_EN
- Defined: every register write, mapped or not, goes to RSP with rsp_id_o = id. rsp_data_o = the value now held (write data if mapped, 0 if unmapped).
- Undefined: writes produce no response, as described above.

Test Plan:
- Write 0x1000 to addr 0x10, then read 0x10 with id 0x5A -> free_list_ptr_o[0]=0x1000 at N+1; read response id 0x5A, data 0x1000.
- Alloc sizes 1, 64, 65, 200, 1000 -> cmd_data 64/64/128/256/1024; cmd_class 0/0/1/2/3 (NUM_CLASSES=4, 1000 saturates at 3).
- Alloc with cmd_ready_i held low 5 cycles -> cmd_* stable, in_ready_o=0 throughout; one handshake, then IDLE.
- Alloc size 0xFFFF_FFFF_FFFF_FFF0 -> rsp data 0, no cmd_valid_o, err_cnt_o=1.
- Free of ptr 0x2040 -> cmd_free_o=1, data 0x2040. Free of 0 -> dropped, err_cnt_o increments. Opcode 7 -> dropped, err_cnt_o increments.
- Assert rst_ni low during PAYLOAD after a written lock_id=3 -> lock_id_o=0, valids 0, next header parsed normally.
